// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, ALUOp encodings and the control bundle shared by the pipelined control unit
package ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW = 6'd35;
  localparam logic [5:0] OP_SW = 6'd43;
  localparam logic [5:0] OP_BEQ = 6'd4;
  localparam logic [5:0] OP_BNE = 6'd5;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  typedef struct packed {
    logic reg_dst;
    logic alu_src;
    logic [1:0] alu_op;
    logic branch;
    logic branch_ne;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
  } ctrl_bundle_t;
  localparam ctrl_bundle_t BUBBLE = '0;
endpackage

// File: rtl/ctrl_decoder.sv
// ctrl_decoder: combinational opcode (valid, opcode) to control bundle (bundle) plus legality flag (legal)
module ctrl_decoder
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter bit BNE_EN = 1'b1,
  parameter bit ADDI_EN = 1'b1
) (
  input  logic                valid,
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_bundle_t        bundle,
  output logic                legal
);
  always_comb begin
    bundle = BUBBLE;
    legal = 1'b1;
    case (opcode)
      OPCODE_W'(OP_RTYPE): begin
        bundle.reg_dst = 1'b1;
        bundle.reg_write = 1'b1;
        bundle.alu_op = ALU_FUNCT;
      end
      OPCODE_W'(OP_LW): begin
        bundle.alu_src = 1'b1;
        bundle.mem_read = 1'b1;
        bundle.mem_to_reg = 1'b1;
        bundle.reg_write = 1'b1;
        bundle.alu_op = ALU_ADD;
      end
      OPCODE_W'(OP_SW): begin
        bundle.alu_src = 1'b1;
        bundle.mem_write = 1'b1;
        bundle.alu_op = ALU_ADD;
      end
      OPCODE_W'(OP_BEQ): begin
        bundle.branch = 1'b1;
        bundle.alu_op = ALU_SUB;
      end
      OPCODE_W'(OP_BNE): begin
        bundle.branch = BNE_EN;
        bundle.branch_ne = BNE_EN;
        bundle.alu_op = BNE_EN ? ALU_SUB : ALU_ADD;
        legal = BNE_EN;
      end
      OPCODE_W'(OP_ADDI): begin
        bundle.alu_src = ADDI_EN;
        bundle.reg_write = ADDI_EN;
        bundle.alu_op = ALU_ADD;
        legal = ADDI_EN;
      end
      default: legal = 1'b0;
    endcase
    if (!valid) bundle = BUBBLE;
  end
endmodule

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: ID decode carried through ID/EX, EX/MEM, MEM/WB with load-use stall, MEM branch flush and saturating stall/flush counters
module pipelined_control_unit
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int REG_W = 5,
  parameter int CNT_W = 16,
  parameter bit BNE_EN = 1'b1,
  parameter bit ADDI_EN = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [OPCODE_W-1:0] id_opcode,
  input  logic [REG_W-1:0]    id_rs,
  input  logic [REG_W-1:0]    id_rt,
  input  logic                ex_zero,
  output logic                ex_reg_dst,
  output logic                ex_alu_src,
  output logic [1:0]          ex_alu_op,
  output logic                mem_mem_read,
  output logic                mem_mem_write,
  output logic                wb_reg_write,
  output logic                wb_mem_to_reg,
  output logic                pc_write,
  output logic                ifid_write,
  output logic                flush,
  output logic                branch_taken,
  output logic                illegal_op,
  output logic [CNT_W-1:0]    stall_count,
  output logic [CNT_W-1:0]    flush_count
);
  ctrl_bundle_t id_b, idex_b;
  logic id_legal, uses_rt, stall, hold;
  logic idex_valid;
  logic [REG_W-1:0] idex_rt;
  logic exmem_valid, exmem_branch, exmem_branch_ne, exmem_mem_read, exmem_mem_write;
  logic exmem_reg_write, exmem_mem_to_reg, exmem_zero;
  logic memwb_valid, memwb_reg_write, memwb_mem_to_reg;
  ctrl_decoder #(.OPCODE_W(OPCODE_W), .BNE_EN(BNE_EN), .ADDI_EN(ADDI_EN)) u_dec (
    .valid(id_valid),
    .opcode(id_opcode),
    .bundle(id_b),
    .legal(id_legal)
  );
  assign uses_rt = id_b.reg_dst | id_b.mem_write | id_b.branch;
  assign stall = idex_valid & idex_b.mem_read & id_valid & (idex_rt != '0) &
                 ((idex_rt == id_rs) | ((idex_rt == id_rt) & uses_rt));
  assign branch_taken = exmem_valid & exmem_branch & (exmem_branch_ne ? ~exmem_zero : exmem_zero);
  assign flush = branch_taken;
  assign hold = stall & ~flush;
  assign pc_write = ~hold;
  assign ifid_write = ~hold;
  assign illegal_op = id_valid & ~id_legal & ~stall & ~flush;
  assign ex_reg_dst = idex_valid & idex_b.reg_dst;
  assign ex_alu_src = idex_valid & idex_b.alu_src;
  assign ex_alu_op = idex_valid ? idex_b.alu_op : 2'b00;
  assign mem_mem_read = exmem_valid & exmem_mem_read;
  assign mem_mem_write = exmem_valid & exmem_mem_write;
  assign wb_reg_write = memwb_valid & memwb_reg_write;
  assign wb_mem_to_reg = memwb_valid & memwb_mem_to_reg;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_valid <= 1'b0;
      idex_b <= BUBBLE;
      idex_rt <= '0;
      exmem_valid <= 1'b0;
      {exmem_branch, exmem_branch_ne, exmem_mem_read, exmem_mem_write} <= '0;
      {exmem_reg_write, exmem_mem_to_reg, exmem_zero} <= '0;
      {memwb_valid, memwb_reg_write, memwb_mem_to_reg} <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      idex_valid <= id_valid & id_legal & ~stall & ~flush;
      idex_b <= (stall | flush) ? BUBBLE : id_b;
      idex_rt <= id_rt;
      exmem_valid <= idex_valid & ~flush;
      exmem_branch <= idex_b.branch;
      exmem_branch_ne <= idex_b.branch_ne;
      exmem_mem_read <= idex_b.mem_read;
      exmem_mem_write <= idex_b.mem_write;
      exmem_reg_write <= idex_b.reg_write;
      exmem_mem_to_reg <= idex_b.mem_to_reg;
      exmem_zero <= ex_zero;
      memwb_valid <= exmem_valid;
      memwb_reg_write <= exmem_reg_write;
      memwb_mem_to_reg <= exmem_mem_to_reg;
      if (hold && !(&stall_count)) stall_count <= stall_count + CNT_W'(1);
      if (flush && !(&flush_count)) flush_count <= flush_count + CNT_W'(1);
    end
  end
endmodule

// File: doc/pipelined_control_unit.md
# pipelined_control_unit

Pipelined successor to the single-cycle MIPS control decoder. It decodes the ID-stage opcode into a control bundle and carries that bundle through ID/EX, EX/MEM and MEM/WB registers. It also detects load-use hazards (stall), resolves branches in MEM (flush), and keeps saturating stall and flush counters. It sits between the IF/ID register and the datapath stage registers of the 5-stage pipeline.

## Interface
- `OPCODE_W`, 6, opcode width
- `REG_W`, 5, register-address width
- `CNT_W`, 16, width of each performance counter
- `BNE_EN`, 1, decode opcode 5 (bne)
- `ADDI_EN`, 1, decode opcode 8 (addi)

Ports:
- `clk`  in  1  pipeline clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `id_valid`  in  1  IF/ID holds a real instruction
- `id_opcode`  in  OPCODE_W  opcode in ID
- `id_rs`, `id_rt`  in  REG_W  source registers in ID
- `ex_zero`  in  1  ALU zero flag from EX
- `ex_reg_dst`, `ex_alu_src`  out  1  EX-stage muxes
- `ex_alu_op`  out  2  to the ALU control
- `mem_mem_read`, `mem_mem_write`  out  1  data-memory strobes
- `wb_reg_write`, `wb_mem_to_reg`  out  1  write-back controls
- `pc_write`, `ifid_write`  out  1  0 freezes PC and IF/ID
- `flush`  out  1  datapath clears IF/ID
- `branch_taken`  out  1  selects the branch target for the PC
- `illegal_op`  out  1  one-cycle pulse for an undecodable valid opcode
- `stall_count`, `flush_count`  out  CNT_W  saturating event counters

## Operation
- Decode (combinational, ID stage):
  - R-type (0): RegDst=1, RegWrite=1, ALUOp=10.
  - lw (35): ALUSrc=1, MemRead=1, MemtoReg=1, RegWrite=1, ALUOp=00.
  - sw (43): ALUSrc=1, MemWrite=1, ALUOp=00.
  - beq (4): Branch=1, ALUOp=01.
  - bne (5, BNE_EN=1): Branch=1, BranchNe=1, ALUOp=01.
  - addi (8, ADDI_EN=1): ALUSrc=1, RegWrite=1, ALUOp=00.
  - Any other opcode, or a disabled one: all-zero bundle (bubble). `illegal_op`=1 only if `id_valid`=1 and no stall or flush is active.
  - `id_valid`=0 always yields a bubble.
- Each stage register holds a valid bit, its bundle, and rt (ID/EX only, used for hazard detection).
- Load-use hazard:
  - Condition: `stall` = ID/EX.MemRead & id_valid & (ID/EX.rt == id_rs | (ID/EX.rt == id_rt & ID uses rt)).
  - ID uses rt for R-type, sw, beq and bne.
  - rt = 0 never stalls.
- Branch resolution in MEM:
  - EX/MEM registers `ex_zero`.
  - `branch_taken` = EX/MEM.Branch & (BranchNe ? ~zero : zero).
- Flush (`flush` = `branch_taken`): the next edge loads bubbles into ID/EX and EX/MEM. MEM/WB still accepts the branch bundle, which has no write effects.
- Priority: flush over stall. During a flush, `pc_write`=1 and the stall is ignored.
- Stall: `pc_write`=`ifid_write`=0, and ID/EX loads a bubble on the next edge.
- Counters: +1 per cycle with `stall` (no flush) or with `flush`. They saturate at all-ones and never wrap.

## Timing
- Reset (async): all stage registers are bubbles. Every control output, `flush`, `branch_taken` and `illegal_op` is 0. `pc_write`=`ifid_write`=1. Both counters are 0.
- Latency of an opcode at ID in cycle n:
  - EX outputs in n+1.
  - MEM outputs in n+2.
  - WB outputs in n+3.
- `stall`, `pc_write`, `ifid_write`, `flush`, `branch_taken` and `illegal_op` are combinational from the current stage registers and ID inputs, valid in the same cycle.
- A load-use stall lasts exactly one cycle. When the lw reaches MEM, ID/EX.MemRead=0.
- Reset mid-stall or mid-flush discards everything. The first edge after reset release behaves as from an empty pipeline.

## Structure
- Shared package `ctrl_pkg`: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI), ALUOp encodings, and the `ctrl_bundle_t` struct (RegDst, ALUSrc, ALUOp, Branch, BranchNe, MemRead, MemWrite, RegWrite, MemtoReg). Also the BUBBLE constant.
- Sub-module `ctrl_decoder`: purely combinational opcode-to-bundle decoder plus the legality flag, parametrised on BNE_EN and ADDI_EN. Stage registers, hazard logic and counters stay in the top module.

## Test plan
- R-type (opcode 0) then three bubbles:
  - cycle n+1: `ex_reg_dst`=1, `ex_alu_op`=10.
  - cycle n+3: `wb_reg_write`=1, `wb_mem_to_reg`=0.
- lw with rt=7, followed by an R-type with rs=7:
  - one stall cycle (`pc_write`=0), then the R-type proceeds. `stall_count`=1.
  - Repeat with rs=0, rt=0: no stall.
- beq with `ex_zero`=1 in its EX cycle:
  - next cycle `branch_taken`=`flush`=1, and the two following instructions reach WB as bubbles. `flush_count`=1.
  - Same test with `ex_zero`=0: no flush.
- bne with BNE_EN=0:
  - `illegal_op` pulses for 1 cycle, and the bundle is a bubble at every stage.
  - With BNE_EN=1 and `ex_zero`=0: taken.
- Stall and flush in the same cycle: the flush wins, `pc_write`=1, and only `flush_count` increments.
- Force CNT_W=2 with 5 stalls: `stall_count` holds at 3. Asserting `reset` mid-stall zeros all outputs and counters asynchronously.
